// File: rtl/alu_md_pkg.sv
// rtl/alu_md_pkg.sv - opcodes, FSM states and op-class decode for alu_md
package alu_md_pkg;

    localparam int ALU_OP_WIDTH = 5;

    typedef enum logic [ALU_OP_WIDTH-1:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_AND    = 5'd2,
        OP_OR     = 5'd3,
        OP_XOR    = 5'd4,
        OP_SHL    = 5'd5,
        OP_SHR    = 5'd6,
        OP_SHRA   = 5'd7,
        OP_EQ     = 5'd8,
        OP_NEQ    = 5'd9,
        OP_LT     = 5'd10,
        OP_LTU    = 5'd11,
        OP_GE     = 5'd12,
        OP_GEU    = 5'd13,
        OP_MUL    = 5'd16,
        OP_MULH   = 5'd17,
        OP_MULHSU = 5'd18,
        OP_MULHU  = 5'd19,
        OP_DIV    = 5'd20,
        OP_DIVU   = 5'd21,
        OP_REM    = 5'd22,
        OP_REMU   = 5'd23
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_e;

    // Multiply ops occupy 16..19, divide ops 20..23; bit 0 clear = signed, bit 1 set = remainder.
    function automatic logic is_mul_op(input logic [ALU_OP_WIDTH-1:0] op);
        return op[4:2] == 3'b100;
    endfunction

    function automatic logic is_div_op(input logic [ALU_OP_WIDTH-1:0] op);
        return op[4:2] == 3'b101;
    endfunction

endpackage

// File: rtl/alu_md_div.sv
// rtl/alu_md_div.sv - radix-2 restoring divider, one quotient bit per enabled cycle
module alu_md_div #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en_i,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic            signed_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] quo_o,
    output logic [XLEN-1:0] rem_o
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0] LAST = CW'(XLEN);

    logic            run_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] acc_q, quo_q, dvs_q, dvd_q;
    logic            neg_quo_q, neg_rem_q, dz_q;

    logic            a_neg, b_neg, ge;
    logic [XLEN:0]   shl, diff;
    logic [XLEN-1:0] quo_fix, rem_fix;

    assign a_neg = signed_i & a_i[XLEN-1];
    assign b_neg = signed_i & b_i[XLEN-1];
    assign shl   = {acc_q, quo_q[XLEN-1]};
    assign diff  = shl - {1'b0, dvs_q};
    assign ge    = ~diff[XLEN];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q     <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            dvd_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
        end else if (en_i) begin
            if (abort_i) begin
                run_q <= 1'b0;
                cnt_q <= '0;
            end else if (start_i) begin
                run_q     <= 1'b1;
                cnt_q     <= '0;
                acc_q     <= '0;
                quo_q     <= a_neg ? -a_i : a_i;
                dvs_q     <= b_neg ? -b_i : b_i;
                dvd_q     <= a_i;
                neg_quo_q <= a_neg ^ b_neg;
                neg_rem_q <= a_neg;
                dz_q      <= (b_i == '0);
            end else if (run_q) begin
                if (cnt_q == LAST) begin
                    run_q <= 1'b0;
                    cnt_q <= '0;
                end else begin
                    acc_q <= ge ? diff[XLEN-1:0] : shl[XLEN-1:0];
                    quo_q <= {quo_q[XLEN-2:0], ge};
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    // Sign fix-up happens combinationally in the final cycle; the top registers it.
    assign quo_fix = neg_quo_q ? -quo_q : quo_q;
    assign rem_fix = neg_rem_q ? -acc_q : acc_q;
    assign done_o  = run_q && (cnt_q == LAST);
    assign quo_o   = dz_q ? '1 : quo_fix;
    assign rem_o   = dz_q ? dvd_q : rem_fix;

endmodule

// File: rtl/alu_md.sv
// rtl/alu_md.sv - single-cycle ALU with pipelined multiplier and iterative divider
module alu_md
    import alu_md_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ROB_W   = 4,
    parameter int MUL_LAT = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    flush,
    input  logic                    rs_ready,
    input  logic [ALU_OP_WIDTH-1:0] rs_op,
    input  logic [XLEN-1:0]         rs_val1,
    input  logic [XLEN-1:0]         rs_val2,
    input  logic [ROB_W-1:0]        rs_id,
    output logic                    alu_busy,
    output logic                    alu_ready,
    output logic [XLEN-1:0]         alu_res,
    output logic [ROB_W-1:0]        alu_id
);
    localparam int SHW = $clog2(XLEN);

    md_state_e       state_q, state_d;
    logic            ready_q, ready_d;
    logic [XLEN-1:0] res_q, res_d;
    logic [ROB_W-1:0] id_q, id_d, tag_q, mul_tag;
    logic            div_rem_q;

    logic            accept, op_mul, op_div, acc_sc, acc_mul, acc_div;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] sc_res, mul_sel, mul_out, div_quo, div_rem;
    logic            mul_done, div_done, a_sgn, b_sgn;
    logic [2*XLEN-1:0] mul_a, mul_b, mul_p;

    assign op_mul  = is_mul_op(rs_op);
    assign op_div  = is_div_op(rs_op);
    assign accept  = rdy & rs_ready & ~alu_busy & ~flush;
    assign acc_mul = accept & op_mul;
    assign acc_div = accept & op_div;
    assign acc_sc  = accept & ~op_mul & ~op_div;
    assign shamt   = rs_val2[SHW-1:0];

    always_comb begin
        sc_res = '0;
        case (alu_op_e'(rs_op))
            OP_ADD:  sc_res = rs_val1 + rs_val2;
            OP_SUB:  sc_res = rs_val1 - rs_val2;
            OP_AND:  sc_res = rs_val1 & rs_val2;
            OP_OR:   sc_res = rs_val1 | rs_val2;
            OP_XOR:  sc_res = rs_val1 ^ rs_val2;
            OP_SHL:  sc_res = rs_val1 << shamt;
            OP_SHR:  sc_res = rs_val1 >> shamt;
            OP_SHRA: sc_res = $unsigned($signed(rs_val1) >>> shamt);
            OP_EQ:   sc_res = XLEN'(rs_val1 == rs_val2);
            OP_NEQ:  sc_res = XLEN'(rs_val1 != rs_val2);
            OP_LT:   sc_res = XLEN'($signed(rs_val1) < $signed(rs_val2));
            OP_LTU:  sc_res = XLEN'(rs_val1 < rs_val2);
            OP_GE:   sc_res = XLEN'($signed(rs_val1) >= $signed(rs_val2));
            OP_GEU:  sc_res = XLEN'(rs_val1 >= rs_val2);
            default: sc_res = '0;
        endcase
    end

    // Sign-extend to 2*XLEN so one unsigned multiply covers all RV32M signedness cases.
    assign a_sgn   = (rs_op == OP_MULH) || (rs_op == OP_MULHSU);
    assign b_sgn   = (rs_op == OP_MULH);
    assign mul_a   = {{XLEN{a_sgn & rs_val1[XLEN-1]}}, rs_val1};
    assign mul_b   = {{XLEN{b_sgn & rs_val2[XLEN-1]}}, rs_val2};
    assign mul_p   = mul_a * mul_b;
    assign mul_sel = (rs_op == OP_MUL) ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];

    generate
        if (MUL_LAT == 1) begin : g_mul_direct
            assign mul_done = acc_mul;
            assign mul_out  = mul_sel;
            assign mul_tag  = rs_id;
        end else begin : g_mul_pipe
            localparam int D = MUL_LAT - 1;
            logic [D-1:0]    mv_q;
            logic [XLEN-1:0] md_q [D];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mv_q <= '0;
                    for (int i = 0; i < D; i++) md_q[i] <= '0;
                end else if (rdy) begin
                    if (flush) begin
                        mv_q <= '0;
                    end else begin
                        mv_q[0] <= acc_mul;
                        md_q[0] <= mul_sel;
                        for (int i = 1; i < D; i++) begin
                            mv_q[i] <= mv_q[i-1];
                            md_q[i] <= md_q[i-1];
                        end
                    end
                end
            end

            assign mul_done = mv_q[D-1];
            assign mul_out  = md_q[D-1];
            assign mul_tag  = tag_q;
        end
    endgenerate

    alu_md_div #(.XLEN(XLEN)) u_div (
        .clk      (clk),
        .rst      (rst),
        .en_i     (rdy),
        .start_i  (acc_div),
        .abort_i  (flush),
        .signed_i (~rs_op[0]),
        .a_i      (rs_val1),
        .b_i      (rs_val2),
        .done_o   (div_done),
        .quo_o    (div_quo),
        .rem_o    (div_rem)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else if (rdy) begin
            state_q <= state_d;
        end
    end

    // Busy covers every cycle up to and including the one presenting the result.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (acc_mul)      state_d = ST_MUL;
                    else if (acc_div) state_d = ST_DIV;
                end
                ST_MUL, ST_DIV: begin
                    if (ready_q) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        alu_busy = (state_q != ST_IDLE);
    end

    always_comb begin
        ready_d = 1'b0;
        res_d   = res_q;
        id_d    = id_q;
        if (acc_sc) begin
            ready_d = 1'b1;
            res_d   = sc_res;
            id_d    = rs_id;
        end else if (mul_done) begin
            ready_d = 1'b1;
            res_d   = mul_out;
            id_d    = mul_tag;
        end else if (div_done) begin
            ready_d = 1'b1;
            res_d   = div_rem_q ? div_rem : div_quo;
            id_d    = tag_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q   <= 1'b0;
            res_q     <= '0;
            id_q      <= '0;
            tag_q     <= '0;
            div_rem_q <= 1'b0;
        end else if (rdy) begin
            if (flush) begin
                ready_q <= 1'b0;
            end else begin
                ready_q <= ready_d;
                res_q   <= res_d;
                id_q    <= id_d;
            end
            if (acc_mul || acc_div) tag_q <= rs_id;
            if (acc_div) div_rem_q <= rs_op[1];
        end
    end

    assign alu_ready = ready_q;
    assign alu_res   = res_q;
    assign alu_id    = id_q;

endmodule

// File: tb/tb_alu_md.sv
// tb/tb_alu_md.sv - directed-vector self-checking bench for alu_md
module tb_alu_md;
    import alu_md_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy, flush, rs_ready;
    logic [4:0]  rs_op;
    logic [31:0] rs_val1, rs_val2;
    logic [3:0]  rs_id;
    logic        alu_busy, alu_ready;
    logic [31:0] alu_res;
    logic [3:0]  alu_id;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_md #(.XLEN(32), .ROB_W(4), .MUL_LAT(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .flush    (flush),
        .rs_ready (rs_ready),
        .rs_op    (rs_op),
        .rs_val1  (rs_val1),
        .rs_val2  (rs_val2),
        .rs_id    (rs_id),
        .alu_busy (alu_busy),
        .alu_ready(alu_ready),
        .alu_res  (alu_res),
        .alu_id   (alu_id)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] id,
                          input logic [31:0] exp_res, input int exp_lat, input int exp_busy,
                          input int stall_at, input bit spam);
        int lat, bsy, extra;
        @(negedge clk);
        rs_op = op; rs_val1 = a; rs_val2 = b; rs_id = id; rs_ready = 1'b1;
        lat = 0;
        bsy = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) rs_ready = 1'b0;
            if (spam && lat == 3) begin
                rs_op = OP_ADD; rs_val1 = 32'd1; rs_val2 = 32'd1; rs_id = 4'hF; rs_ready = 1'b1;
            end
            if (spam && lat == 4) rs_ready = 1'b0;
            if (stall_at != 0 && lat == stall_at) rdy = 1'b0;
            if (stall_at != 0 && lat == stall_at + 5) rdy = 1'b1;
            if (alu_busy) bsy++;
        end while (!alu_ready && lat < 100);
        check_eq({tag, ".lat"}, lat, exp_lat);
        check_eq({tag, ".res"}, alu_res, exp_res);
        check_eq({tag, ".id"}, {28'd0, alu_id}, {28'd0, id});
        check_eq({tag, ".busy"}, bsy, exp_busy);
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (alu_ready) extra++;
        end
        check_eq({tag, ".extra"}, extra, 0);
    endtask

    initial begin
        int n, seen;
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; rs_ready = 1'b0;
        rs_op = '0; rs_val1 = '0; rs_val2 = '0; rs_id = '0;
        repeat (2) @(negedge clk);
        check_eq("rst.ready", {31'd0, alu_ready}, 32'd0);
        check_eq("rst.res", alu_res, 32'd0);
        check_eq("rst.id", {28'd0, alu_id}, 32'd0);
        check_eq("rst.busy", {31'd0, alu_busy}, 32'd0);
        rst = 1'b0;

        run_op("add",   OP_ADD,  32'h7FFFFFFF, 32'h1, 4'd3, 32'h80000000, 1, 0, 0, 1'b0);
        run_op("sub",   OP_SUB,  32'd5, 32'd7, 4'd1, 32'hFFFFFFFE, 1, 0, 0, 1'b0);
        run_op("and",   OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 4'd2, 32'hF000F000, 1, 0, 0, 1'b0);
        run_op("or",    OP_OR,   32'hF0F0F0F0, 32'hFF00FF00, 4'd4, 32'hFFF0FFF0, 1, 0, 0, 1'b0);
        run_op("xor",   OP_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 4'd5, 32'h0FF00FF0, 1, 0, 0, 1'b0);
        run_op("shl",   OP_SHL,  32'h1, 32'h24, 4'd6, 32'h10, 1, 0, 0, 1'b0);
        run_op("shr",   OP_SHR,  32'h80000000, 32'h21, 4'd7, 32'h40000000, 1, 0, 0, 1'b0);
        run_op("shra",  OP_SHRA, 32'h80000000, 32'h21, 4'd8, 32'hC0000000, 1, 0, 0, 1'b0);
        run_op("eq",    OP_EQ,   32'd5, 32'd5, 4'd9, 32'd1, 1, 0, 0, 1'b0);
        run_op("neq",   OP_NEQ,  32'd5, 32'd5, 4'd10, 32'd0, 1, 0, 0, 1'b0);
        run_op("lt",    OP_LT,   32'hFFFFFFFF, 32'd1, 4'd11, 32'd1, 1, 0, 0, 1'b0);
        run_op("ltu",   OP_LTU,  32'hFFFFFFFF, 32'd1, 4'd12, 32'd0, 1, 0, 0, 1'b0);
        run_op("ge",    OP_GE,   32'hFFFFFFFF, 32'd1, 4'd13, 32'd0, 1, 0, 0, 1'b0);
        run_op("geu",   OP_GEU,  32'hFFFFFFFF, 32'd1, 4'd14, 32'd1, 1, 0, 0, 1'b0);
        run_op("unk",   5'd31,   32'h1234, 32'h5678, 4'd15, 32'd0, 1, 0, 0, 1'b0);

        run_op("mul",    OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 4'd1, 32'h00000001, 2, 2, 0, 1'b0);
        run_op("mul2",   OP_MUL,    32'h00012345, 32'h10, 4'd2, 32'h00123450, 2, 2, 0, 1'b0);
        run_op("mulh",   OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 4'd3, 32'h00000000, 2, 2, 0, 1'b0);
        run_op("mulhu",  OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 4'd4, 32'hFFFFFFFE, 2, 2, 0, 1'b0);
        run_op("mulhsu", OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd5, 32'hFFFFFFFF, 2, 2, 0, 1'b0);

        run_op("div_ovf",  OP_DIV,  32'h80000000, 32'hFFFFFFFF, 4'd6, 32'h80000000, 34, 34, 0, 1'b1);
        run_op("rem_ovf",  OP_REM,  32'h80000000, 32'hFFFFFFFF, 4'd7, 32'h0, 34, 34, 0, 1'b0);
        run_op("divu_z",   OP_DIVU, 32'd7, 32'd0, 4'd8, 32'hFFFFFFFF, 34, 34, 0, 1'b0);
        run_op("remu_z",   OP_REMU, 32'd7, 32'd0, 4'd9, 32'd7, 34, 34, 0, 1'b0);
        run_op("div_neg",  OP_DIV,  32'hFFFFFFF9, 32'd2, 4'd10, 32'hFFFFFFFD, 34, 34, 0, 1'b0);
        run_op("rem_neg",  OP_REM,  32'hFFFFFFF9, 32'd2, 4'd11, 32'hFFFFFFFF, 34, 34, 0, 1'b0);
        run_op("rem_z",    OP_REM,  32'hFFFFFFF9, 32'd0, 4'd12, 32'hFFFFFFF9, 34, 34, 0, 1'b0);
        run_op("divu",     OP_DIVU, 32'd100, 32'd7, 4'd13, 32'd14, 34, 34, 0, 1'b0);
        run_op("remu",     OP_REMU, 32'd100, 32'd7, 4'd14, 32'd2, 34, 34, 0, 1'b0);

        // Flush in the middle of a divide, with an op presented during the flush cycle.
        @(negedge clk);
        rs_op = OP_DIVU; rs_val1 = 32'd100; rs_val2 = 32'd7; rs_id = 4'd5; rs_ready = 1'b1;
        n = 0;
        seen = 0;
        while (n < 10) begin
            @(negedge clk);
            n++;
            if (n == 1) rs_ready = 1'b0;
            if (alu_ready) seen++;
        end
        flush = 1'b1;
        rs_op = OP_ADD; rs_val1 = 32'd1; rs_val2 = 32'd1; rs_id = 4'd7; rs_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        rs_ready = 1'b0;
        check_eq("flush.busy", {31'd0, alu_busy}, 32'd0);
        check_eq("flush.ready", {31'd0, alu_ready}, 32'd0);
        check_eq("flush.early", seen, 0);
        run_op("post_flush", OP_ADD, 32'd2, 32'd3, 4'd6, 32'd5, 1, 0, 0, 1'b0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (alu_ready) seen++;
        end
        check_eq("flush.ghost", seen, 0);

        run_op("div_stall", OP_DIVU, 32'd100, 32'd7, 4'd9, 32'd14, 39, 39, 10, 1'b1);

        // Asynchronous reset while a multiply is in flight.
        @(negedge clk);
        rs_op = OP_MULHU; rs_val1 = 32'hFFFFFFFF; rs_val2 = 32'hFFFFFFFF; rs_id = 4'd11; rs_ready = 1'b1;
        @(negedge clk);
        rs_ready = 1'b0;
        check_eq("mrst.pre_busy", {31'd0, alu_busy}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("mrst.ready", {31'd0, alu_ready}, 32'd0);
        check_eq("mrst.res", alu_res, 32'd0);
        check_eq("mrst.id", {28'd0, alu_id}, 32'd0);
        check_eq("mrst.busy", {31'd0, alu_busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (alu_ready) seen++;
        end
        check_eq("mrst.ghost", seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_md.md
ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 Parameter XLEN, default 32, operand/result width.
REQ-002 Parameter ROB_W, default 4, ROB id width.
REQ-003 Parameter MUL_LAT, default 2, multiply latency in cycles (range 1..4).
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 rdy  input  1  global enable; low freezes all state and outputs.
REQ-007 flush  input  1  mispredict flush; discards accepted and in-flight work.
REQ-008 rs_ready  input  1  RS issue valid.
REQ-009 rs_op  input  `ALU_OP_WIDTH  operation code.
REQ-010 rs_val1 / rs_val2  input  XLEN  operands.
REQ-011 rs_id  input  ROB_W  ROB tag of issued op.
REQ-012 alu_busy  output  1  combinational; high when a multi-cycle op is in flight; RS SHALL NOT issue while high.
REQ-013 alu_ready  output  1  registered result-valid pulse, one cycle per op.
REQ-014 alu_res  output  XLEN  registered result.
REQ-015 alu_id  output  ROB_W  registered ROB tag of result.

Function
REQ-016 Issue accepted when rdy & rs_ready & !alu_busy & !flush; rs_ready while alu_busy is ignored (op dropped, no result).
REQ-017 Single-cycle ops (ADD, SUB, AND, OR, XOR, SHL, SHR, SHRA, EQ, NEQ, LT, LTU, GE, GEU) produce alu_ready the cycle after acceptance; compare ops return 1 or 0 zero-extended.
REQ-018 Shift ops use only rs_val2[$clog2(XLEN)-1:0]; SHRA sign-fills from rs_val1[XLEN-1].
REQ-019 MUL/MULH/MULHSU/MULHU: MUL returns low XLEN bits, others high XLEN bits of 2*XLEN product with RV32M signedness; alu_ready exactly MUL_LAT cycles after acceptance.
REQ-020 DIV/DIVU/REM/REMU: radix-2 restoring, one quotient bit per cycle; alu_ready exactly XLEN+2 cycles after acceptance (1 setup, XLEN iterate, 1 fix-up/sign).
REQ-021 Divide by zero: quotient all-ones, remainder = dividend, latency unchanged.
REQ-022 Signed overflow (most-negative / -1): quotient = dividend, remainder 0.
REQ-023 Control FSM states IDLE, MUL, DIV; IDLE->MUL/DIV on accepted multi-cycle op; MUL/DIV->IDLE in cycle result registered; alu_busy = (state != IDLE).
REQ-024 At most one result per cycle; no single-cycle op can collide because issue blocked while busy.
REQ-025 Flush: state->IDLE, counters cleared, alu_ready low next cycle; op presented in flush cycle not accepted; issue allowed cycle after flush.
REQ-026 rdy low: state, counters, pipeline, and outputs hold values; alu_ready held too (consumer also gated by rdy).
REQ-027 alu_res/alu_id hold last value when alu_ready low.
REQ-028 Unknown opcode: result 0, single-cycle latency.

Reset
REQ-029 On rst high, immediately: alu_ready=0, alu_res=0, alu_id=0, state IDLE, divider counter 0, mul pipeline valids 0.
REQ-030 Reset mid-DIV or mid-MUL aborts op with no result after release.

Structure
REQ-031 ALU_* and new MUL/DIV op codes, XLEN defaults, op-class decode macros belong in global_params.v.
REQ-032 Iterative divider is sub-module alu_div (start, signed/rem select, operands, done, quotient, remainder, abort); multiplier and single-cycle datapath stay in alu_md.

Verification
REQ-033 ADD 0x7FFFFFFF+1, id 3 -> next cycle alu_ready=1, res 0x80000000, id 3.
REQ-034 MULH 0xFFFFFFFF x 0xFFFFFFFF (MUL_LAT=2) -> res 0x00000000 after 2 cycles; MULHU same -> 0xFFFFFFFE; alu_busy high 2 cycles.
REQ-035 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 after 34 cycles; REM -> 0; DIVU 7/0 -> 0xFFFFFFFF, REMU 7/0 -> 7.
REQ-036 DIV issued, flush at cycle 10 -> no alu_ready, alu_busy low next cycle; ADD 2+3 issued next -> res 5.
REQ-037 rdy low 5 cycles during DIV -> result arrives 5 cycles later, value unchanged; rs_ready while busy -> no extra result.
REQ-038 SHRA 0x80000000 by 0x21 -> 0xC0000000 (shift 1); rst asserted mid-MUL -> all outputs 0 asynchronously.
